// File: rtl/aes_pkg.sv
// Shared AES definitions: key scheduler control encodings,
// AES-128 round count and the key sequencer state type.
package aes_pkg;

  localparam logic [1:0] KS_HOLD = 2'b00;
  localparam logic [1:0] KS_LOAD = 2'b01;
  localparam logic [1:0] KS_FWD  = 2'b10;
  localparam logic [1:0] KS_REV  = 2'b11;

  localparam int AES128_NR = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREROLL,
    ST_PRESENT
  } ks_state_e;

endpackage

// File: rtl/aes128_key_sched_ctrl.sv
// AES-128 key schedule sequencer: loads the cipher key, pre-rolls to
// round 10 for decryption, and streams round keys over valid/ready.
// Ports: clk/rst_n, start/decrypt/abort/key_in (command side),
// busy/done (status), sched_* (scheduler control and key return),
// rk_out/rk_idx/rk_valid/rk_ready (round key stream).
module aes128_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             decrypt,
  input  logic             abort,
  input  logic [127:0]     key_in,
  output logic             busy,
  output logic             done,
  output logic [1:0]       sched_ctrl,
  output logic [IDX_W-1:0] sched_round,
  output logic [127:0]     sched_load_key,
  input  logic [127:0]     sched_key_q,
  output logic [127:0]     rk_out,
  output logic [IDX_W-1:0] rk_idx,
  output logic             rk_valid,
  input  logic             rk_ready
);

  localparam logic [IDX_W-1:0] NR_IDX = IDX_W'(NUM_ROUNDS);
  localparam logic [IDX_W-1:0] ONE    = IDX_W'(1);

  ks_state_e        state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [IDX_W-1:0] pre_cnt, pre_d;
  logic             mode, mode_d;
  logic             done_q, done_d;
  logic             hs;

  assign rk_valid       = (state == ST_PRESENT);
  assign rk_idx         = idx;
  assign rk_out         = sched_key_q;
  assign sched_load_key = key_in;
  assign busy           = (state != ST_IDLE);
  assign done           = done_q;
  assign hs             = rk_valid & rk_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      pre_cnt <= '0;
      mode    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      pre_cnt <= pre_d;
      mode    <= mode_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d     = state;
    idx_d       = idx;
    pre_d       = pre_cnt;
    mode_d      = mode;
    done_d      = 1'b0;
    sched_ctrl  = KS_HOLD;
    sched_round = '0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            sched_ctrl = KS_LOAD;
            mode_d     = decrypt;
            if (decrypt) begin
              state_d = ST_PREROLL;
              pre_d   = ONE;
            end else begin
              state_d = ST_PRESENT;
              idx_d   = '0;
            end
          end
        end
        ST_PREROLL: begin
          sched_ctrl  = KS_FWD;
          sched_round = pre_cnt;
          if (pre_cnt == NR_IDX) begin
            state_d = ST_PRESENT;
            idx_d   = NR_IDX;
          end else begin
            pre_d = pre_cnt + ONE;
          end
        end
        ST_PRESENT: begin
          if (hs) begin
            unique case (1'b1)
              (!mode && idx < NR_IDX): begin
                sched_ctrl  = KS_FWD;
                sched_round = idx + ONE;
                idx_d       = idx + ONE;
              end
              (mode && idx != '0): begin
                // rcon of the key being undone is its own index
                sched_ctrl  = KS_REV;
                sched_round = idx;
                idx_d       = idx - ONE;
              end
              default: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            endcase
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_key_sched_ctrl.sv
// Directed bench for the AES-128 key sequencer with a behavioural
// key scheduler attached; expected keys are the FIPS-197 A.1 values.
module tb_aes128_key_sched_ctrl;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         decrypt = 1'b0;
  logic         abort = 1'b0;
  logic         rk_ready = 1'b1;
  logic [127:0] key_in = '0;
  logic         busy, done, rk_valid;
  logic [1:0]   sched_ctrl;
  logic [3:0]   sched_round, rk_idx;
  logic [127:0] sched_load_key, sched_key_q, rk_out;
  logic [127:0] ks;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic [127:0] rk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [31:0] subrot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sb(r[31:24]), sb(r[23:16]), sb(r[15:8]), sb(r[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1: return 8'h01;
      4'd2: return 8'h02;
      4'd3: return 8'h04;
      4'd4: return 8'h08;
      4'd5: return 8'h10;
      4'd6: return 8'h20;
      4'd7: return 8'h40;
      4'd8: return 8'h80;
      4'd9: return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] ks_fwd(input logic [127:0] k,
                                          input logic [3:0] r);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ subrot(k[31:0]) ^ {rcon(r), 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] ks_rev(input logic [127:0] k,
                                          input logic [3:0] r);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0] ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ subrot(p3) ^ {rcon(r), 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  always_ff @(posedge clk) begin
    case (sched_ctrl)
      KS_LOAD: ks <= sched_load_key;
      KS_FWD:  ks <= ks_fwd(ks, sched_round);
      KS_REV:  ks <= ks_rev(ks, sched_round);
      default: ks <= ks;
    endcase
  end
  assign sched_key_q = ks;

  always #5 clk = ~clk;

  aes128_key_sched_ctrl #(.NUM_ROUNDS(10), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt),
    .abort(abort), .key_in(key_in), .busy(busy), .done(done),
    .sched_ctrl(sched_ctrl), .sched_round(sched_round),
    .sched_load_key(sched_load_key), .sched_key_q(sched_key_q),
    .rk_out(rk_out), .rk_idx(rk_idx), .rk_valid(rk_valid),
    .rk_ready(rk_ready)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an encrypt at the current drive point and checks all 11 keys;
  // returns at the drive point of the done cycle.
  task automatic run_enc();
    key_in  = KEY;
    decrypt = 1'b0;
    start   = 1'b1;
    #1;
    chk("enc_load", sched_ctrl, KS_LOAD);
    chk("load_pass", sched_load_key, KEY);
    for (int i = 0; i <= 10; i++) begin
      tick();
      start  = 1'b0;
      key_in = '0;
      #1;
      chk("enc_valid", rk_valid, 1'b1);
      chk("enc_idx", rk_idx, i);
      chk("enc_key", rk_out, rk[i]);
      chk("enc_done_lo", done, 1'b0);
      chk("enc_ctrl", sched_ctrl, (i < 10) ? KS_FWD : KS_HOLD);
      if (i < 10) chk("enc_round", sched_round, i + 1);
    end
    tick();
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", rk_valid, 1'b0);
    chk("rst_idx", rk_idx, 4'd0);
    chk("rst_ctrl", sched_ctrl, KS_HOLD);
    chk("rst_round", sched_round, 4'd0);
    chk("rst_done", done, 1'b0);
    #10 rst_n = 1'b1;

    // encrypt with ready held high
    tick();
    run_enc();
    #1;
    chk("enc_done", done, 1'b1);
    chk("enc_busy_end", busy, 1'b0);
    chk("enc_valid_end", rk_valid, 1'b0);
    tick();
    #1;
    chk("enc_done_clr", done, 1'b0);

    // decrypt: ten pre-roll cycles then keys 10..0
    key_in  = KEY;
    decrypt = 1'b1;
    start   = 1'b1;
    #1;
    chk("dec_load", sched_ctrl, KS_LOAD);
    for (int i = 1; i <= 10; i++) begin
      tick();
      start   = 1'b0;
      decrypt = 1'b0;
      #1;
      chk("pre_ctrl", sched_ctrl, KS_FWD);
      chk("pre_round", sched_round, i);
      chk("pre_valid", rk_valid, 1'b0);
      chk("pre_busy", busy, 1'b1);
    end
    for (int i = 10; i >= 0; i--) begin
      tick();
      #1;
      chk("dec_valid", rk_valid, 1'b1);
      chk("dec_idx", rk_idx, i);
      chk("dec_key", rk_out, rk[i]);
      chk("dec_ctrl", sched_ctrl, (i > 0) ? KS_REV : KS_HOLD);
      if (i > 0) chk("dec_round", sched_round, i);
      chk("dec_done_lo", done, 1'b0);
    end
    tick();
    #1;
    chk("dec_done", done, 1'b1);
    tick();
    #1;
    chk("dec_done_once", done, 1'b0);

    // backpressure at idx3, stray start at idx5
    key_in = KEY;
    start  = 1'b1;
    #1;
    for (int i = 0; i <= 10; i++) begin
      tick();
      start    = 1'b0;
      rk_ready = 1'b1;
      if (i == 3) begin
        rk_ready = 1'b0;
        repeat (5) begin
          #1;
          chk("bp_idx", rk_idx, 4'd3);
          chk("bp_key", rk_out, rk[3]);
          chk("bp_ctrl", sched_ctrl, KS_HOLD);
          chk("bp_valid", rk_valid, 1'b1);
          tick();
        end
        rk_ready = 1'b1;
      end
      if (i == 5) start = 1'b1;
      #1;
      chk("bp_seq_idx", rk_idx, i);
      chk("bp_seq_key", rk_out, rk[i]);
      chk("bp_seq_ctrl", sched_ctrl, (i < 10) ? KS_FWD : KS_HOLD);
    end
    tick();
    #1;
    chk("bp_done", done, 1'b1);

    // start with abort in IDLE
    tick();
    start = 1'b1;
    abort = 1'b1;
    #1;
    chk("sa_ctrl", sched_ctrl, KS_HOLD);
    tick();
    start = 1'b0;
    abort = 1'b0;
    #1;
    chk("sa_busy", busy, 1'b0);
    chk("sa_valid", rk_valid, 1'b0);

    // abort during pre-roll at pre_cnt 4
    key_in  = KEY;
    decrypt = 1'b1;
    start   = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      start   = 1'b0;
      decrypt = 1'b0;
      #1;
      chk("ab_round", sched_round, i);
    end
    abort = 1'b1;
    #1;
    chk("ab_ctrl", sched_ctrl, KS_HOLD);
    tick();
    abort = 1'b0;
    #1;
    chk("ab_busy", busy, 1'b0);
    chk("ab_done", done, 1'b0);
    tick();
    #1;
    chk("ab_done2", done, 1'b0);
    key_in = KEY;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #1;
    chk("ab_re_idx", rk_idx, 4'd1);
    chk("ab_re_key", rk_out, rk[1]);

    // asynchronous reset mid-PRESENT
    tick();
    rst_n = 1'b0;
    #1;
    chk("ar_valid", rk_valid, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_done", done, 1'b0);
    chk("ar_ctrl", sched_ctrl, KS_HOLD);
    chk("ar_idx", rk_idx, 4'd0);
    #2 rst_n = 1'b1;

    // fresh start, then back-to-back start in the done cycle
    tick();
    run_enc();
    #1;
    chk("b2b_done", done, 1'b1);
    run_enc();
    #1;
    chk("b2b_done2", done, 1'b1);
    tick();
    #1;
    chk("b2b_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
